// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_hazard_ctrl
//  Purpose  : ID-stage branch operand forwarding, stall sequencing, taken
//             flush and saturating branch performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_hazard_ctrl #(
  parameter int EX_FWD_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IF_ID_Branch,
  input  logic             IF_ID_Bne,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_MEM_RegWrite,
  input  logic             EX_MEM_MemRead,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             MEM_WB_RegWrite,
  input  logic [4:0]       MEM_WB_rd,
  input  logic             cmp_eq,
  output logic [1:0]       FA,
  output logic [1:0]       FB,
  output logic             stall,
  output logic             PCSrc,
  output logic             IF_ID_Flush,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [1:0]       c_SEL_RF  = 2'b00;
  localparam logic [1:0]       c_SEL_EX  = 2'b01;
  localparam logic [1:0]       c_SEL_MEM = 2'b10;
  localparam logic [1:0]       c_SEL_WB  = 2'b11;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cnt;
  logic [1:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [3:0]       w_rs_res;
  logic [3:0]       w_rt_res;
  logic [1:0]       w_need;

  // Returns {cycles still needed, source select}; the youngest producer wins.
  function automatic logic [3:0] f_resolve(input logic [4:0] op);
    logic w_ex;
    logic w_mem;
    logic w_wb;
    w_ex  = ID_EX_RegWrite  && (ID_EX_rd  == op) && (op != 5'd0);
    w_mem = EX_MEM_RegWrite && (EX_MEM_rd == op) && (op != 5'd0);
    w_wb  = MEM_WB_RegWrite && (MEM_WB_rd == op) && (op != 5'd0);
    f_resolve = {2'd0, c_SEL_RF};
    if (w_ex) begin
      if (ID_EX_MemRead)
        f_resolve = {2'd2, c_SEL_EX};
      else if (EX_FWD_EN != 0)
        f_resolve = {2'd0, c_SEL_EX};
      else
        f_resolve = {2'd1, c_SEL_EX};
    end else if (w_mem) begin
      f_resolve = EX_MEM_MemRead ? {2'd1, c_SEL_MEM} : {2'd0, c_SEL_MEM};
    end else if (w_wb) begin
      f_resolve = {2'd0, c_SEL_WB};
    end
  endfunction

  always_comb begin
    w_rs_res = f_resolve(IF_ID_rs);
    w_rt_res = f_resolve(IF_ID_rt);
    w_need   = (w_rs_res[3:2] > w_rt_res[3:2]) ? w_rs_res[3:2] : w_rt_res[3:2];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    FA          = c_SEL_RF;
    FB          = c_SEL_RF;
    stall       = 1'b0;
    PCSrc       = 1'b0;
    IF_ID_Flush = 1'b0;
    if (IF_ID_Branch) begin
      FA = w_rs_res[1:0];
      FB = w_rt_res[1:0];
    end
    case (r_state)
      S_IDLE: begin
        if (IF_ID_Branch) begin
          if (w_need != 2'd0) begin
            stall     = 1'b1;
            w_cnt_nxt = w_need - 2'd1;
            if (w_need > 2'd1)
              w_state_nxt = S_WAIT;
          end else begin
            PCSrc       = cmp_eq ^ IF_ID_Bne;
            IF_ID_Flush = cmp_eq ^ IF_ID_Bne;
          end
        end
      end
      S_WAIT: begin
        // Branch inputs are deliberately ignored until the countdown ends.
        stall     = 1'b1;
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt == 2'd1)
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_taken_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (PCSrc && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + c_CNT_ONE;
      if (stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
    end
  end

  assign taken_cnt = r_taken_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_hazard_ctrl
//  Purpose  : Self-checking bench for branch_hazard_ctrl (two parameter sets).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_hazard_ctrl;

  typedef struct {
    logic       br, bne, cmp, rst;
    logic [4:0] rs, rt;
    logic       exw, exl;
    logic [4:0] exd;
    logic       mw, ml;
    logic [4:0] md;
    logic       ww;
    logic [4:0] wd;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [1:0] fa, fb;
    logic       st, pc, st2;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, br, bne, cmp, exw, exl, mw, ml, ww;
  logic [4:0] rs, rt, exd, md, wd;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        st0, pc0, fl0, st1, pc1, fl1;
  logic [15:0] tk0, sc0;
  logic [3:0]  tk1, sc1;

  int n_pass = 0;
  int n_total = 0;

  branch_hazard_ctrl #(.EX_FWD_EN(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(rst), .IF_ID_Branch(br), .IF_ID_Bne(bne),
    .IF_ID_rs(rs), .IF_ID_rt(rt),
    .ID_EX_RegWrite(exw), .ID_EX_MemRead(exl), .ID_EX_rd(exd),
    .EX_MEM_RegWrite(mw), .EX_MEM_MemRead(ml), .EX_MEM_rd(md),
    .MEM_WB_RegWrite(ww), .MEM_WB_rd(wd), .cmp_eq(cmp),
    .FA(fa0), .FB(fb0), .stall(st0), .PCSrc(pc0), .IF_ID_Flush(fl0),
    .taken_cnt(tk0), .stall_cnt(sc0)
  );

  branch_hazard_ctrl #(.EX_FWD_EN(0), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(rst), .IF_ID_Branch(br), .IF_ID_Bne(bne),
    .IF_ID_rs(rs), .IF_ID_rt(rt),
    .ID_EX_RegWrite(exw), .ID_EX_MemRead(exl), .ID_EX_rd(exd),
    .EX_MEM_RegWrite(mw), .EX_MEM_MemRead(ml), .EX_MEM_rd(md),
    .MEM_WB_RegWrite(ww), .MEM_WB_rd(wd), .cmp_eq(cmp),
    .FA(fa1), .FB(fb1), .stall(st1), .PCSrc(pc1), .IF_ID_Flush(fl1),
    .taken_cnt(tk1), .stall_cnt(sc1)
  );

  // Reference model: remaining forced-stall cycles plus counter values.
  int m_hold[2] = '{0, 0};
  int m_tk[2]   = '{0, 0};
  int m_sc[2]   = '{0, 0};
  bit m_valid   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Cycles until operand usable: loads need (2 - stage age); oldest match scanned first so youngest wins.
  function automatic void m_need(input logic [4:0] op, input bit fwd, output int n, output int sel);
    logic       wr[3];
    logic [4:0] dst[3];
    logic       ld[3];
    wr  = '{exw, mw, ww};
    dst = '{exd, md, wd};
    ld  = '{exl, ml, 1'b0};
    n = 0; sel = 0;
    for (int i = 2; i >= 0; i--) begin
      if (wr[i] && dst[i] == op && op != 5'd0) begin
        sel = i + 1;
        if (ld[i]) n = 2 - i;
        else if (i == 0 && !fwd) n = 1;
        else n = 0;
      end
    end
  endfunction

  function automatic void m_expect(input int d, output int st, output int pc,
                                   output int fa, output int fb, output int n);
    int na, nb;
    m_need(rs, d == 0, na, fa);
    m_need(rt, d == 0, nb, fb);
    n = (na > nb) ? na : nb;
    st = 0; pc = 0;
    if (m_hold[d] > 0) st = 1;
    else if (!br) begin fa = 0; fb = 0; n = 0; end
    else if (n > 0) st = 1;
    else pc = int'(cmp ^ bne);
  endfunction

  always @(posedge clk) begin
    int st, pc, fa, fb, n, mx;
    for (int d = 0; d < 2; d++) begin
      m_expect(d, st, pc, fa, fb, n);
      mx = (d == 0) ? 65535 : 15;
      if (rst) begin
        m_hold[d] = 0; m_tk[d] = 0; m_sc[d] = 0;
      end else begin
        if (st != 0 && m_sc[d] < mx) m_sc[d]++;
        if (pc != 0 && m_tk[d] < mx) m_tk[d]++;
        if (m_hold[d] > 0) m_hold[d]--;
        else if (br && n > 0) m_hold[d] = n - 1;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  task automatic model_check();
    int st, pc, fa, fb, n;
    for (int d = 0; d < 2; d++) begin
      m_expect(d, st, pc, fa, fb, n);
      chk($sformatf("m_stall%0d", d), d ? int'(st1) : int'(st0), st);
      chk($sformatf("m_pcsrc%0d", d), d ? int'(pc1) : int'(pc0), pc);
      chk($sformatf("m_flush%0d", d), d ? int'(fl1) : int'(fl0), pc);
      if (st == 0) begin
        chk($sformatf("m_fa%0d", d), d ? int'(fa1) : int'(fa0), fa);
        chk($sformatf("m_fb%0d", d), d ? int'(fb1) : int'(fb0), fb);
      end
      chk($sformatf("m_takencnt%0d", d), d ? int'(tk1) : int'(tk0), m_tk[d]);
      chk($sformatf("m_stallcnt%0d", d), d ? int'(sc1) : int'(sc0), m_sc[d]);
    end
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    rst = s.rst; br = s.br; bne = s.bne; cmp = s.cmp; rs = s.rs; rt = s.rt;
    exw = s.exw; exl = s.exl; exd = s.exd; mw = s.mw; ml = s.ml; md = s.md;
    ww = s.ww; wd = s.wd;
    #2;
    if (m_valid) model_check();
  endtask

  function automatic stim_t mk(input logic br_i, bne_i, cmp_i, input logic [4:0] rs_i, rt_i,
                               input logic exw_i, exl_i, input logic [4:0] exd_i,
                               input logic mw_i, ml_i, input logic [4:0] md_i,
                               input logic ww_i, input logic [4:0] wd_i);
    stim_t s;
    s.br = br_i; s.bne = bne_i; s.cmp = cmp_i; s.rst = 1'b0;
    s.rs = rs_i; s.rt = rt_i; s.exw = exw_i; s.exl = exl_i; s.exd = exd_i;
    s.mw = mw_i; s.ml = ml_i; s.md = md_i; s.ww = ww_i; s.wd = wd_i;
    return s;
  endfunction

  task automatic do_reset();
    stim_t s;
    s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s.rst = 1'b1;
    drive(s);
    drive(s);
  endtask

  vec_t  vt[13];
  stim_t idle, s;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //          br bne cmp rs rt  exw exl exd mw ml md  ww wd        fa fb st pc st2
    vt[0].s  = mk(0, 0, 1, 16, 17, 1, 0, 16, 1, 0, 17, 1, 16); vt[0].fa  = 0; vt[0].fb  = 0; vt[0].st  = 0; vt[0].pc  = 0; vt[0].st2  = 0;
    vt[1].s  = mk(1, 0, 1, 16, 17, 1, 0, 16, 0, 0, 0,  0, 0);  vt[1].fa  = 1; vt[1].fb  = 0; vt[1].st  = 0; vt[1].pc  = 1; vt[1].st2  = 1;
    vt[2].s  = mk(1, 1, 0, 16, 17, 1, 1, 16, 0, 0, 0,  0, 0);  vt[2].fa  = 0; vt[2].fb  = 0; vt[2].st  = 1; vt[2].pc  = 0; vt[2].st2  = 1;
    vt[3].s  = mk(1, 0, 1, 16, 17, 0, 0, 0,  1, 1, 17, 0, 0);  vt[3].fa  = 0; vt[3].fb  = 0; vt[3].st  = 1; vt[3].pc  = 0; vt[3].st2  = 1;
    vt[4].s  = mk(1, 0, 0, 16, 17, 0, 0, 0,  1, 0, 17, 0, 0);  vt[4].fa  = 0; vt[4].fb  = 2; vt[4].st  = 0; vt[4].pc  = 0; vt[4].st2  = 0;
    vt[5].s  = mk(1, 1, 0, 16, 17, 0, 0, 0,  0, 0, 0,  1, 17); vt[5].fa  = 0; vt[5].fb  = 3; vt[5].st  = 0; vt[5].pc  = 1; vt[5].st2  = 0;
    vt[6].s  = mk(1, 0, 1, 0,  17, 1, 0, 0,  0, 0, 0,  0, 0);  vt[6].fa  = 0; vt[6].fb  = 0; vt[6].st  = 0; vt[6].pc  = 1; vt[6].st2  = 0;
    vt[7].s  = mk(1, 0, 0, 5,  6,  1, 0, 5,  1, 0, 5,  0, 0);  vt[7].fa  = 1; vt[7].fb  = 0; vt[7].st  = 0; vt[7].pc  = 0; vt[7].st2  = 1;
    vt[8].s  = mk(1, 0, 1, 5,  5,  0, 0, 0,  1, 0, 5,  1, 5);  vt[8].fa  = 2; vt[8].fb  = 2; vt[8].st  = 0; vt[8].pc  = 1; vt[8].st2  = 0;
    vt[9].s  = mk(1, 0, 1, 5,  6,  0, 0, 5,  0, 0, 0,  0, 0);  vt[9].fa  = 0; vt[9].fb  = 0; vt[9].st  = 0; vt[9].pc  = 1; vt[9].st2  = 0;
    vt[10].s = mk(1, 1, 1, 5,  6,  0, 0, 0,  0, 0, 0,  0, 0);  vt[10].fa = 0; vt[10].fb = 0; vt[10].st = 0; vt[10].pc = 0; vt[10].st2 = 0;
    vt[11].s = mk(1, 0, 1, 7,  9,  1, 0, 7,  0, 0, 0,  1, 9);  vt[11].fa = 1; vt[11].fb = 3; vt[11].st = 0; vt[11].pc = 1; vt[11].st2 = 1;
    vt[12].s = mk(1, 0, 1, 7,  9,  0, 0, 0,  0, 0, 0,  0, 9);  vt[12].fa = 0; vt[12].fb = 0; vt[12].st = 0; vt[12].pc = 1; vt[12].st2 = 0;

    do_reset();
    chk("rst_stall", int'(st0), 0);
    chk("rst_pcsrc", int'(pc0), 0);
    chk("rst_takencnt", int'(tk0), 0);
    chk("rst_stallcnt", int'(sc0), 0);

    // Vectors applied with reset held so every one is evaluated from IDLE.
    for (int i = 0; i < 13; i++) begin
      s = vt[i].s;
      s.rst = 1'b1;
      drive(s);
      chk($sformatf("vec%0d_stall", i), int'(st0), int'(vt[i].st));
      chk($sformatf("vec%0d_stall_nofwd", i), int'(st1), int'(vt[i].st2));
      if (!vt[i].st) begin
        chk($sformatf("vec%0d_fa", i), int'(fa0), int'(vt[i].fa));
        chk($sformatf("vec%0d_fb", i), int'(fb0), int'(vt[i].fb));
        chk($sformatf("vec%0d_pcsrc", i), int'(pc0), int'(vt[i].pc));
        chk($sformatf("vec%0d_flush", i), int'(fl0), int'(vt[i].pc));
      end
    end

    // ALU producer in EX feeding a taken beq.
    do_reset();
    drive(mk(1, 0, 1, 16, 17, 1, 0, 16, 0, 0, 0, 0, 0));
    chk("alu_fa", int'(fa0), 1);
    chk("alu_pcsrc", int'(pc0), 1);
    chk("alu_flush", int'(fl0), 1);
    drive(idle);
    chk("alu_takencnt", int'(tk0), 1);

    // Load in EX feeding bne: two stall cycles, then WB forward.
    do_reset();
    drive(mk(1, 1, 0, 16, 17, 1, 1, 16, 0, 0, 0, 0, 0));
    chk("ld_stall_c1", int'(st0), 1);
    drive(mk(1, 1, 0, 16, 17, 0, 0, 0, 1, 1, 16, 0, 0));
    chk("ld_stall_c2", int'(st0), 1);
    drive(mk(1, 1, 1, 16, 17, 0, 0, 0, 0, 0, 0, 1, 16));
    chk("ld_stall_c3", int'(st0), 0);
    chk("ld_fa", int'(fa0), 3);
    chk("ld_pcsrc", int'(pc0), 0);
    chk("ld_stallcnt", int'(sc0), 2);

    // Load in MEM: one stall then WB forward on rt.
    do_reset();
    drive(mk(1, 0, 1, 3, 17, 0, 0, 0, 1, 1, 17, 0, 0));
    chk("mld_stall", int'(st0), 1);
    drive(mk(1, 0, 1, 3, 17, 0, 0, 0, 0, 0, 0, 1, 17));
    chk("mld_stall2", int'(st0), 0);
    chk("mld_fb", int'(fb0), 3);
    chk("mld_pcsrc", int'(pc0), 1);

    // No EX forwarding: ALU producer in EX costs one cycle, then MEM forward.
    do_reset();
    drive(mk(1, 0, 1, 3, 17, 1, 0, 17, 0, 0, 0, 0, 0));
    chk("nofwd_stall", int'(st1), 1);
    drive(mk(1, 0, 1, 3, 17, 0, 0, 0, 1, 0, 17, 0, 0));
    chk("nofwd_stall2", int'(st1), 0);
    chk("nofwd_fb", int'(fb1), 2);

    // Reset during the first stall cycle abandons the sequence.
    do_reset();
    drive(mk(1, 1, 0, 16, 17, 1, 1, 16, 0, 0, 0, 0, 0));
    s = mk(1, 1, 0, 16, 17, 0, 0, 0, 1, 1, 16, 0, 0);
    s.rst = 1'b1;
    drive(s);
    drive(idle);
    chk("rstwait_stall", int'(st0), 0);
    chk("rstwait_stallcnt", int'(sc0), 0);
    chk("rstwait_takencnt", int'(tk0), 0);

    // Saturation at 4 bits.
    do_reset();
    repeat (20) drive(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(idle);
    chk("sat_takencnt4", int'(tk1), 15);
    chk("sat_takencnt16", int'(tk0), 20);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      s = mk(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 5'($urandom_range(0, 3)));
      s.rst = ($urandom_range(0, 39) == 0);
      drive(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Sequences ID-stage branch resolution in the 5-stage MIPS pipeline. Branches are resolved early in ID, and source operands may come from EX, MEM or WB.
- Per branch operand, selects the operand source: register file, EX ALU result, EX/MEM ALU result, or MEM/WB write data.
- Stalls the front end when a needed value is not yet produced. Issues PCSrc and the IF/ID flush when a branch is taken.
- Keeps saturating performance counters for taken branches and branch stall cycles.

Parameters:
- EX_FWD_EN, 1: 1 = an ALU producer in EX is forwarded from EX with 0 stall; 0 = that case costs 1 stall cycle instead.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- IF_ID_Branch  in  1  instruction in ID is beq/bne
- IF_ID_Bne  in  1  1 = bne, 0 = beq
- IF_ID_rs  in  5  ID source register rs
- IF_ID_rt  in  5  ID source register rt
- ID_EX_RegWrite  in  1  EX-stage instruction writes a register
- ID_EX_MemRead  in  1  EX-stage instruction is a load
- ID_EX_rd  in  5  EX-stage destination register
- EX_MEM_RegWrite  in  1  MEM-stage instruction writes a register
- EX_MEM_MemRead  in  1  MEM-stage instruction is a load
- EX_MEM_rd  in  5  MEM-stage destination register
- MEM_WB_RegWrite  in  1  WB-stage instruction writes a register
- MEM_WB_rd  in  5  WB-stage destination register
- cmp_eq  in  1  ID comparator result on the forwarded operands
- FA  out  2  rs source select: 00 RF, 01 EX ALU, 10 EX/MEM, 11 MEM/WB
- FB  out  2  rt source select, same encoding as FA
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
- PCSrc  out  1  branch taken; PC loads branch target
- IF_ID_Flush  out  1  zero IF/ID on the next edge
- taken_cnt  out  CNT_W  count of taken branches, saturating
- stall_cnt  out  CNT_W  count of branch stall cycles, saturating

Behaviour:
- Match rule: a stage matches an operand when its RegWrite=1, its rd equals the operand, and rd!=0.
- Match priority is EX > MEM > WB; the most recent producer wins.
- Per-operand need N, evaluated only when IF_ID_Branch=1:
  - EX match with MemRead: N=2.
  - EX match, ALU producer: N=0, sel=01 if EX_FWD_EN=1; otherwise N=1.
  - MEM match with MemRead: N=1.
  - MEM match, ALU producer: N=0, sel=10.
  - WB match: N=0, sel=11.
  - No match: N=0, sel=00.
- Operand need is the maximum of rs and rt. The operand with the highest priority match determines sel.
- When IF_ID_Branch=0: FA=FB=00 and the block does nothing.
- FSM states: IDLE and WAIT, plus a 2-bit counter cnt.
- IDLE, branch with N>0:
  - stall=1 combinationally in the same cycle; PCSrc=0.
  - cnt<=N-1; go to WAIT if N-1>0, else stay in IDLE.
  - Operands are re-evaluated in the next cycle because producers have advanced.
- IDLE, branch with N=0 (resolve cycle):
  - PCSrc = cmp_eq XOR IF_ID_Bne.
  - IF_ID_Flush = PCSrc; stall=0.
  - FA/FB are valid this cycle.
- WAIT:
  - stall=1, PCSrc=0, IF_ID_Flush=0.
  - cnt<=cnt-1; return to IDLE when cnt==1.
  - Branch inputs are not re-sampled in WAIT.
- All outputs are combinational from the state and inputs. stall and PCSrc are never 1 in the same cycle.
- stall_cnt increments on every cycle with stall=1; taken_cnt increments on every cycle with PCSrc=1.
- Both counters saturate at all-ones and do not wrap.
- Reset, including mid-WAIT: state=IDLE, cnt=0, both counters 0.
  - In the first cycle after reset, outputs follow the IDLE rules. With IF_ID_Branch=0 they are all 0.
  - The stall sequence of an interrupted branch is abandoned.

Test Plan:
- ALU-to-branch: EX: addi $16 (RegWrite=1, MemRead=0, rd=16); ID: beq $16,$17, cmp_eq=1 -> same cycle FA=01, FB=00, stall=0, PCSrc=1, IF_ID_Flush=1; taken_cnt=1 next cycle.
- Load-to-branch: EX: lw rd=16; ID: bne rs=16 -> stall=1 for 2 cycles, stall_cnt=2. Third cycle: WB rd=16 present, FA=11, stall=0; cmp_eq=1 -> PCSrc=0.
- Load in MEM: MEM: lw rd=17; ID: beq rt=17 -> 1 stall cycle, then FB=11 and resolve. Rerun with EX_FWD_EN=0 and an ALU producer in EX -> 1 stall, then FB=10.
- Register $0 and priority: EX rd=0 with RegWrite=1 -> FA=00, no stall. EX rd=5 and MEM rd=5 both matching rs=5 -> FA=01.
- Reset mid-WAIT: assert reset during the first stall cycle of a load-to-branch -> next cycle stall=0, counters=0, state IDLE.
- Saturation: CNT_W=4, 20 taken branches -> taken_cnt holds at 15.
